// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures period and active time of an asynchronous PWM input
// Rev 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int WAVE_LEN_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      active_high,
  input  logic                      pwm_in,
  output logic [WAVE_LEN_WIDTH-1:0] wave_length_out,
  output logic [WAVE_LEN_WIDTH-1:0] pulse_width_out,
  output logic                      valid,
  output logic                      stuck
);

  localparam logic [WAVE_LEN_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [WAVE_LEN_WIDTH-1:0] c_CNT_ONE = WAVE_LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEEK     = 2'd1,
    ACTIVE   = 2'd2,
    INACTIVE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      s1_q, s2_q, a_d_q, ah_q;
  logic [WAVE_LEN_WIDTH-1:0] period_q, period_d;
  logic [WAVE_LEN_WIDTH-1:0] high_q, high_d;
  logic [WAVE_LEN_WIDTH-1:0] wave_q, wave_d;
  logic [WAVE_LEN_WIDTH-1:0] pulse_q, pulse_d;
  logic                      valid_q, valid_d;
  logic                      stuck_q, stuck_d;

  logic                      lvl, rise, fall, sat, pol_flip, sat_report;
  logic [WAVE_LEN_WIDTH-1:0] period_inc;

  // Level is compared against the live polarity so a flip never looks like an edge one cycle later.
  assign lvl        = ~(s2_q ^ active_high);
  assign rise       = lvl & ~a_d_q;
  assign fall       = ~lvl & a_d_q;
  assign sat        = (period_q == c_CNT_MAX);
  assign pol_flip   = active_high ^ ah_q;
  assign period_inc = sat ? period_q : period_q + c_CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_d_q    <= 1'b0;
      ah_q     <= active_high;
      period_q <= '0;
      high_q   <= '0;
      wave_q   <= '0;
      pulse_q  <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      a_d_q    <= lvl;
      ah_q     <= active_high;
      period_q <= period_d;
      high_q   <= high_d;
      wave_q   <= wave_d;
      pulse_q  <= pulse_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    high_d     = high_q;
    wave_d     = wave_q;
    pulse_d    = pulse_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;
    sat_report = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
    end else if (pol_flip) begin
      state_d  = SEEK;
      period_d = '0;
      high_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SEEK;
          period_d = '0;
          high_d   = '0;
        end
        SEEK: begin
          if (rise) begin
            state_d  = ACTIVE;
            period_d = c_CNT_ONE;
          end else if (sat) begin
            sat_report = 1'b1;
          end else begin
            period_d = period_inc;
          end
        end
        ACTIVE: begin
          if (fall) begin
            state_d  = INACTIVE;
            high_d   = period_q;
            period_d = period_inc;
          end else if (sat) begin
            sat_report = 1'b1;
          end else begin
            period_d = period_inc;
          end
        end
        INACTIVE: begin
          if (rise) begin
            state_d  = ACTIVE;
            wave_d   = period_q;
            pulse_d  = high_q;
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            period_d = c_CNT_ONE;
          end else if (sat) begin
            sat_report = 1'b1;
          end else begin
            period_d = period_inc;
          end
        end
        default: state_d = IDLE;
      endcase

      // Timeout report: the input has held one level for a full counter range.
      if (sat_report) begin
        state_d  = SEEK;
        wave_d   = c_CNT_MAX;
        pulse_d  = lvl ? c_CNT_MAX : '0;
        valid_d  = 1'b1;
        stuck_d  = 1'b1;
        period_d = c_CNT_ONE;
      end
    end
  end

  assign wave_length_out = wave_q;
  assign pulse_width_out = pulse_q;
  assign valid           = valid_q;
  assign stuck           = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pwm_capture : directed self-checking bench for pwm_capture
// Rev 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         active_high;
  logic         pwm_in;
  logic [W-1:0] wave_length_out;
  logic [W-1:0] pulse_width_out;
  logic         valid;
  logic         stuck;

  int   n_vec   = 0;
  int   n_miss  = 0;
  int   cyc     = 0;
  int   vcount  = 0;
  int   v_cyc   = 0;
  int   t0      = 0;
  int   phase   = 0;
  int   gen_hi  = 0;
  int   gen_per = 10;
  bit   gen_on  = 1'b0;
  logic gen_lvl = 1'b1;
  bit   v_s     = 1'b0;
  int   prev;
  int   vbefore;
  bit   ok;

  always #5 clk = ~clk;

  pwm_capture #(.WAVE_LEN_WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .active_high     (active_high),
    .pwm_in          (pwm_in),
    .wave_length_out (wave_length_out),
    .pulse_width_out (pulse_width_out),
    .valid           (valid),
    .stuck           (stuck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive the next pwm level.
  task automatic step();
    @(negedge clk);
    cyc++;
    v_s = valid;
    if (valid === 1'b1) begin
      vcount++;
      v_cyc = cyc;
    end
    if (gen_on) begin
      pwm_in = (phase < gen_hi) ? gen_lvl : ~gen_lvl;
      phase  = (phase + 1 == gen_per) ? 0 : phase + 1;
    end else begin
      pwm_in = ~gen_lvl;
    end
  endtask

  task automatic wait_report(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (v_s) found = 1'b1;
    end
  endtask

  task automatic expect_report(input string tag, input int wl, input int pw,
                               input bit st, input int budget);
    wait_report(budget, ok);
    check({tag, "_seen"}, 32'(ok), 1);
    if (ok) begin
      check({tag, "_wl"}, 32'(wave_length_out), wl);
      check({tag, "_pw"}, 32'(pulse_width_out), pw);
      check({tag, "_stuck"}, 32'(stuck), 32'(st));
    end
  endtask

  // Restart measurement on a fresh waveform; t0 is the cycle the first active level is driven.
  task automatic start_wave(input int hi, input int per, input logic lvl, input logic ah);
    enable      = 1'b0;
    active_high = ah;
    gen_on      = 1'b0;
    gen_hi      = hi;
    gen_per     = per;
    gen_lvl     = lvl;
    repeat (3) step();
    enable = 1'b1;
    repeat (3) step();
    gen_on = 1'b1;
    phase  = 0;
    step();
    t0 = cyc;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    active_high = 1'b1;
    pwm_in      = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(valid), 0);
    check("rst_wl", 32'(wave_length_out), 0);
    check("rst_pw", 32'(pulse_width_out), 0);
    check("rst_stuck", 32'(stuck), 0);
    reset = 1'b0;
    step();

    // 5 high / 5 low, active high
    start_wave(5, 10, 1'b1, 1'b1);
    expect_report("p10_first", 10, 5, 1'b0, 40);
    check("p10_latency", 32'(v_cyc - t0), 13);
    prev = v_cyc;
    expect_report("p10_second", 10, 5, 1'b0, 20);
    check("p10_gap", 32'(v_cyc - prev), 10);

    // Enable dropped mid-period for 100 cycles
    repeat (3) step();
    enable  = 1'b0;
    vbefore = vcount;
    repeat (100) step();
    check("dis_no_valid", 32'(vcount - vbefore), 0);
    check("dis_hold_wl", 32'(wave_length_out), 10);
    check("dis_hold_pw", 32'(pulse_width_out), 5);
    enable = 1'b1;
    expect_report("reen", 10, 5, 1'b0, 40);

    // Reset while INACTIVE
    repeat (6) step();
    reset = 1'b1;
    step();
    check("mrst_valid", 32'(valid), 0);
    check("mrst_wl", 32'(wave_length_out), 0);
    check("mrst_pw", 32'(pulse_width_out), 0);
    check("mrst_stuck", 32'(stuck), 0);
    reset = 1'b0;
    expect_report("after_rst", 10, 5, 1'b0, 40);

    // 18 of 20, then polarity flipped mid-ACTIVE
    start_wave(18, 20, 1'b1, 1'b1);
    expect_report("p20", 20, 18, 1'b0, 60);
    repeat (3) step();
    active_high = 1'b0;
    expect_report("flip", 20, 2, 1'b0, 80);

    // 1 of 5, minimum-ish period
    start_wave(1, 5, 1'b1, 1'b1);
    expect_report("p5", 5, 1, 1'b0, 30);
    prev = v_cyc;
    expect_report("p5_second", 5, 1, 1'b0, 10);
    check("p5_gap", 32'(v_cyc - prev), 5);

    // Inverted 5/10 with active-low polarity
    start_wave(5, 10, 1'b0, 1'b0);
    expect_report("inv10", 10, 5, 1'b0, 40);

    // Constant low: periodic timeout reports
    start_wave(0, 10, 1'b1, 1'b1);
    expect_report("low_stuck", 255, 0, 1'b1, 300);
    prev = v_cyc;
    expect_report("low_stuck2", 255, 0, 1'b1, 300);
    check("low_gap", 32'(v_cyc - prev), 255);

    // Constant high
    start_wave(10, 10, 1'b1, 1'b1);
    expect_report("high_stuck", 255, 255, 1'b1, 300);
    prev = v_cyc;
    expect_report("high_stuck2", 255, 255, 1'b1, 300);
    check("high_gap", 32'(v_cyc - prev), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
